// File: rtl/qracc_bus_initiator.sv
// qracc_bus_initiator
// Burst bus master for the QRAcc data port. Accepts write/read burst
// commands, streams write payload from a prefillable FIFO onto the
// valid/ready bus, and collects read returns into a first-word-fall-through
// FIFO. Read requests are credit limited so returns can never overflow
// the read FIFO.
// Optional feature: define QRACC_BUS_INITIATOR_TIMEOUT_EN to add a stall
// watchdog that sets a sticky error_o and returns the FSM to IDLE.
module qracc_bus_initiator #(
    parameter int DATA_W         = 128,
    parameter int ADDR_W         = 32,
    parameter int LEN_W          = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_wen_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              abort_i,
    input  logic              wdata_valid_i,
    output logic              wdata_ready_o,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rdata_valid_o,
    input  logic              rdata_ready_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              bus_valid_o,
    input  logic              bus_ready_i,
    output logic              bus_wen_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_rd_data_i,
    input  logic              bus_rd_data_valid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Reject configurations the pointer arithmetic cannot handle.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
        $error("qracc_bus_initiator: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Burst context
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [LEN_W-1:0]  r_returned;
    logic [CNT_W-1:0]  r_outstanding;

    // Write FIFO
    logic [DATA_W-1:0] r_wmem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wf_wr;
    logic [PTR_W-1:0]  r_wf_rd;
    logic [CNT_W-1:0]  r_wf_cnt;

    // Read FIFO
    logic [DATA_W-1:0] r_rmem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_rf_wr;
    logic [PTR_W-1:0]  r_rf_rd;
    logic [CNT_W-1:0]  r_rf_cnt;

    logic w_cmd_ready;
    logic w_cmd_hs;
    logic w_busy;
    logic w_done;
    logic w_wf_full;
    logic w_wf_empty;
    logic w_wf_push;
    logic w_wf_pop;
    logic w_rf_empty;
    logic w_rf_push;
    logic w_rf_pop;
    logic w_has_credit;
    logic w_wr_valid;
    logic w_rd_valid;
    logic w_bus_valid;
    logic w_bus_hs;
    logic w_rd_req;
    logic w_last_wr;
    logic w_last_rd;
    logic w_timeout;
    logic w_flush;

    assign w_wf_full  = (r_wf_cnt == CNT_W'(FIFO_DEPTH));
    assign w_wf_empty = (r_wf_cnt == '0);
    assign w_rf_empty = (r_rf_cnt == '0);

    // Credit = free read-FIFO slots not already promised to an outstanding request.
    assign w_has_credit = ({1'b0, r_rf_cnt} + {1'b0, r_outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);

    assign w_wr_valid  = (r_state == S_WRITE) && !w_wf_empty;
    assign w_rd_valid  = (r_state == S_READ) && (r_issued < r_len) && w_has_credit;
    assign w_bus_valid = w_wr_valid || w_rd_valid;
    assign w_bus_hs    = w_bus_valid && bus_ready_i;
    assign w_rd_req    = w_rd_valid && bus_ready_i;

    assign w_cmd_hs  = cmd_valid_i && w_cmd_ready;
    assign w_wf_push = wdata_valid_i && !w_wf_full;
    assign w_wf_pop  = w_wr_valid && bus_ready_i;
    // Returns outside READ or beyond the burst length are dropped.
    assign w_rf_push = bus_rd_data_valid_i && (r_state == S_READ) && (r_returned != r_len);
    assign w_rf_pop  = !w_rf_empty && rdata_ready_i;

    // WRITE/READ are only entered with a non-zero length, so len-1 cannot underflow there.
    assign w_last_wr = (r_issued == (r_len - LEN_W'(1)));
    assign w_last_rd = w_rf_push && ((r_returned + LEN_W'(1)) == r_len);

    assign w_flush = abort_i || w_timeout;

`ifdef QRACC_BUS_INITIATOR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_error;
    logic            w_stall;

    assign w_stall   = w_bus_valid && !bus_ready_i;
    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle; abort takes precedence.
    assign w_timeout = w_stall && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !abort_i;
    assign error_o   = r_error;

    // Stall watchdog and sticky error flag (only reset clears the flag).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_to_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            if (abort_i || w_timeout || !w_stall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign error_o   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and status outputs; flush (abort/timeout) overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_cmd_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy      = 1'b0;
                w_cmd_ready = 1'b1;
                if (cmd_valid_i) begin
                    if (cmd_len_i == '0) begin
                        w_state_nxt = S_DONE;
                    end else if (cmd_wen_i) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (w_wf_pop && w_last_wr) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_READ: begin
                if (w_last_rd) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Burst context: latch the command, then track issued/returned beats and in-flight reads.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_base        <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_returned    <= '0;
            r_outstanding <= '0;
        end else if (w_flush) begin
            r_issued      <= '0;
            r_returned    <= '0;
            r_outstanding <= '0;
        end else if (w_cmd_hs) begin
            r_base        <= cmd_addr_i;
            r_len         <= cmd_len_i;
            r_issued      <= '0;
            r_returned    <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_bus_hs) begin
                r_issued <= r_issued + LEN_W'(1);
            end
            if (w_rf_push) begin
                r_returned <= r_returned + LEN_W'(1);
            end
            if (w_rd_req && !w_rf_push) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (!w_rd_req && w_rf_push && (r_outstanding != '0)) begin
                r_outstanding <= r_outstanding - CNT_W'(1);
            end
        end
    end

    // Write FIFO storage (data path, not reset).
    always_ff @(posedge clk) begin
        if (w_wf_push && !w_flush) begin
            r_wmem[r_wf_wr] <= wdata_i;
        end
    end

    // Write FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wf_wr  <= '0;
            r_wf_rd  <= '0;
            r_wf_cnt <= '0;
        end else if (w_flush) begin
            r_wf_wr  <= '0;
            r_wf_rd  <= '0;
            r_wf_cnt <= '0;
        end else begin
            if (w_wf_push) begin
                r_wf_wr <= r_wf_wr + PTR_W'(1);
            end
            if (w_wf_pop) begin
                r_wf_rd <= r_wf_rd + PTR_W'(1);
            end
            r_wf_cnt <= r_wf_cnt + CNT_W'(w_wf_push) - CNT_W'(w_wf_pop);
        end
    end

    // Read FIFO storage (data path, not reset).
    always_ff @(posedge clk) begin
        if (w_rf_push && !w_flush) begin
            r_rmem[r_rf_wr] <= bus_rd_data_i;
        end
    end

    // Read FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rf_wr  <= '0;
            r_rf_rd  <= '0;
            r_rf_cnt <= '0;
        end else if (w_flush) begin
            r_rf_wr  <= '0;
            r_rf_rd  <= '0;
            r_rf_cnt <= '0;
        end else begin
            if (w_rf_push) begin
                r_rf_wr <= r_rf_wr + PTR_W'(1);
            end
            if (w_rf_pop) begin
                r_rf_rd <= r_rf_rd + PTR_W'(1);
            end
            r_rf_cnt <= r_rf_cnt + CNT_W'(w_rf_push) - CNT_W'(w_rf_pop);
        end
    end

    // Address/data are zeroed while no request is offered so outputs never show stale storage.
    assign bus_valid_o   = w_bus_valid;
    assign bus_wen_o     = w_wr_valid;
    assign bus_addr_o    = w_bus_valid ? (r_base + ADDR_W'(r_issued)) : '0;
    assign bus_data_o    = w_wr_valid ? r_wmem[r_wf_rd] : '0;
    assign rdata_valid_o = !w_rf_empty;
    assign rdata_o       = w_rf_empty ? '0 : r_rmem[r_rf_rd];
    assign wdata_ready_o = !w_wf_full;
    assign cmd_ready_o   = w_cmd_ready;
    assign busy_o        = w_busy;
    assign done_o        = w_done;

endmodule

// File: tb/tb_qracc_bus_initiator.sv
// Directed testbench for qracc_bus_initiator: write burst with prefill,
// credit-limited read burst with backpressure, zero-length command,
// address wrap, abort mid-read, and stall watchdog behaviour.
module tb_qracc_bus_initiator;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    logic              clk;
    logic              nrst;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_wen_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [LEN_W-1:0]  cmd_len_i;
    logic              abort_i;
    logic              wdata_valid_i;
    logic              wdata_ready_o;
    logic [DATA_W-1:0] wdata_i;
    logic              rdata_valid_o;
    logic              rdata_ready_i;
    logic [DATA_W-1:0] rdata_o;
    logic              bus_valid_o;
    logic              bus_ready_i;
    logic              bus_wen_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_data_o;
    logic [DATA_W-1:0] bus_rd_data_i;
    logic              bus_rd_data_valid_i;
    logic              busy_o;
    logic              done_o;
    logic              error_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wrap_exp [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};

    qracc_bus_initiator #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W(LEN_W),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_wen_i(cmd_wen_i),
        .cmd_addr_i(cmd_addr_i),
        .cmd_len_i(cmd_len_i),
        .abort_i(abort_i),
        .wdata_valid_i(wdata_valid_i),
        .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i),
        .rdata_valid_o(rdata_valid_o),
        .rdata_ready_i(rdata_ready_i),
        .rdata_o(rdata_o),
        .bus_valid_o(bus_valid_o),
        .bus_ready_i(bus_ready_i),
        .bus_wen_o(bus_wen_o),
        .bus_addr_o(bus_addr_o),
        .bus_data_o(bus_data_o),
        .bus_rd_data_i(bus_rd_data_i),
        .bus_rd_data_valid_i(bus_rd_data_valid_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .error_o(error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge (sample point).
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        nrst                = 1'b0;
        cmd_valid_i         = 1'b0;
        cmd_wen_i           = 1'b0;
        cmd_addr_i          = '0;
        cmd_len_i           = '0;
        abort_i             = 1'b0;
        wdata_valid_i       = 1'b0;
        wdata_i             = '0;
        rdata_ready_i       = 1'b0;
        bus_ready_i         = 1'b0;
        bus_rd_data_i       = '0;
        bus_rd_data_valid_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        mid();
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_wdata_ready", wdata_ready_o, 1);
        chk("rst_bus_valid", bus_valid_o, 0);
        chk("rst_bus_wen", bus_wen_o, 0);
        chk("rst_bus_addr", bus_addr_o, 0);
        chk("rst_bus_data", bus_data_o, 0);
        chk("rst_rdata_valid", rdata_valid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_error", error_o, 0);
        nxt();
        nrst = 1'b1;
        mid();
        chk("post_rst_cmd_ready", cmd_ready_o, 1);
        chk("post_rst_busy", busy_o, 0);

        // Write burst: prefill 4 beats, addr 0x10 len 4
        for (int i = 0; i < 4; i++) begin
            nxt();
            wdata_valid_i = 1'b1;
            wdata_i       = 32'hA0 + 32'(i);
            mid();
            chk("wr_prefill_ready", wdata_ready_o, 1);
        end
        nxt();
        wdata_valid_i = 1'b0;
        cmd_valid_i   = 1'b1;
        cmd_wen_i     = 1'b1;
        cmd_addr_i    = 32'h10;
        cmd_len_i     = 16'd4;
        bus_ready_i   = 1'b1;
        mid();
        chk("wr_fifo_full", wdata_ready_o, 0);
        chk("wr_c0_cmd_ready", cmd_ready_o, 1);
        chk("wr_c0_bus_valid", bus_valid_o, 0);
        nxt();
        cmd_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("wr_bus_valid", bus_valid_o, 1);
            chk("wr_bus_wen", bus_wen_o, 1);
            chk("wr_bus_addr", bus_addr_o, 64'(32'h10 + 32'(k)));
            chk("wr_bus_data", bus_data_o, 64'(32'hA0 + 32'(k)));
            chk("wr_cmd_ready_low", cmd_ready_o, 0);
            chk("wr_busy", busy_o, 1);
            chk("wr_no_early_done", done_o, 0);
            nxt();
        end
        mid();
        chk("wr_done", done_o, 1);
        chk("wr_done_bus_idle", bus_valid_o, 0);
        nxt();
        mid();
        chk("wr_after_done", done_o, 0);
        chk("wr_back_idle_ready", cmd_ready_o, 1);
        chk("wr_back_idle_busy", busy_o, 0);

        // Read burst len 6 with rdata backpressure: credit caps requests at 4
        nxt();
        cmd_valid_i   = 1'b1;
        cmd_wen_i     = 1'b0;
        cmd_addr_i    = 32'h100;
        cmd_len_i     = 16'd6;
        bus_ready_i   = 1'b1;
        rdata_ready_i = 1'b0;
        nxt();
        cmd_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("rd_req_valid", bus_valid_o, 1);
            chk("rd_req_wen", bus_wen_o, 0);
            chk("rd_req_addr", bus_addr_o, 64'(32'h100 + 32'(k)));
            nxt();
        end
        mid();
        chk("rd_credit_exhausted", bus_valid_o, 0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            bus_rd_data_valid_i = 1'b1;
            bus_rd_data_i       = 32'hD0 + 32'(k);
            mid();
            chk("rd_no_req_while_full", bus_valid_o, 0);
        end
        nxt();
        bus_rd_data_valid_i = 1'b0;
        rdata_ready_i       = 1'b1;
        mid();
        chk("rd_rvalid", rdata_valid_o, 1);
        chk("rd_data0", rdata_o, 64'h00D0);
        chk("rd_c10_no_credit", bus_valid_o, 0);
        nxt();
        mid();
        chk("rd_data1", rdata_o, 64'h00D1);
        chk("rd_req5_valid", bus_valid_o, 1);
        chk("rd_req5_addr", bus_addr_o, 64'h0104);
        nxt();
        mid();
        chk("rd_data2", rdata_o, 64'h00D2);
        chk("rd_req6_valid", bus_valid_o, 1);
        chk("rd_req6_addr", bus_addr_o, 64'h0105);
        nxt();
        bus_rd_data_valid_i = 1'b1;
        bus_rd_data_i       = 32'hD4;
        mid();
        chk("rd_data3", rdata_o, 64'h00D3);
        chk("rd_all_issued", bus_valid_o, 0);
        chk("rd_not_done_yet", done_o, 0);
        nxt();
        bus_rd_data_i = 32'hD5;
        mid();
        chk("rd_data4", rdata_o, 64'h00D4);
        chk("rd_not_done_c14", done_o, 0);
        nxt();
        bus_rd_data_valid_i = 1'b0;
        mid();
        chk("rd_done", done_o, 1);
        chk("rd_data5_valid", rdata_valid_o, 1);
        chk("rd_data5", rdata_o, 64'h00D5);
        nxt();
        rdata_ready_i = 1'b0;
        mid();
        chk("rd_drained", rdata_valid_o, 0);
        chk("rd_done_cleared", done_o, 0);
        chk("rd_idle", busy_o, 0);

        // Zero-length command
        nxt();
        cmd_valid_i = 1'b1;
        cmd_wen_i   = 1'b0;
        cmd_addr_i  = 32'h55;
        cmd_len_i   = 16'd0;
        mid();
        chk("len0_cmd_ready", cmd_ready_o, 1);
        nxt();
        cmd_valid_i = 1'b0;
        mid();
        chk("len0_done", done_o, 1);
        chk("len0_no_bus", bus_valid_o, 0);
        chk("len0_busy", busy_o, 1);
        nxt();
        mid();
        chk("len0_idle_done", done_o, 0);
        chk("len0_idle_ready", cmd_ready_o, 1);

        // Address wrap on a 3-beat write
        for (int i = 0; i < 3; i++) begin
            nxt();
            wdata_valid_i = 1'b1;
            wdata_i       = 32'hB0 + 32'(i);
        end
        nxt();
        wdata_valid_i = 1'b0;
        cmd_valid_i   = 1'b1;
        cmd_wen_i     = 1'b1;
        cmd_addr_i    = 32'hFFFF_FFFE;
        cmd_len_i     = 16'd3;
        bus_ready_i   = 1'b1;
        nxt();
        cmd_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("wrap_addr", bus_addr_o, 64'(wrap_exp[k]));
            chk("wrap_data", bus_data_o, 64'(32'hB0 + 32'(k)));
            nxt();
        end
        mid();
        chk("wrap_done", done_o, 1);

        // Abort mid-read after two returns
        nxt();
        cmd_valid_i   = 1'b1;
        cmd_wen_i     = 1'b0;
        cmd_addr_i    = 32'h200;
        cmd_len_i     = 16'd4;
        bus_ready_i   = 1'b1;
        rdata_ready_i = 1'b0;
        nxt();
        cmd_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("ab_req_addr", bus_addr_o, 64'(32'h200 + 32'(k)));
            nxt();
        end
        bus_rd_data_valid_i = 1'b1;
        bus_rd_data_i       = 32'hE0;
        mid();
        chk("ab_no_req", bus_valid_o, 0);
        nxt();
        bus_rd_data_i = 32'hE1;
        mid();
        chk("ab_rvalid_before", rdata_valid_o, 1);
        chk("ab_rdata0", rdata_o, 64'h00E0);
        nxt();
        bus_rd_data_valid_i = 1'b0;
        abort_i             = 1'b1;
        mid();
        chk("ab_busy_before", busy_o, 1);
        nxt();
        abort_i             = 1'b0;
        bus_rd_data_valid_i = 1'b1;
        bus_rd_data_i       = 32'hE2;
        mid();
        chk("ab_idle_busy", busy_o, 0);
        chk("ab_flushed", rdata_valid_o, 0);
        chk("ab_no_done", done_o, 0);
        chk("ab_cmd_ready", cmd_ready_o, 1);
        chk("ab_bus_idle", bus_valid_o, 0);
        nxt();
        bus_rd_data_valid_i = 1'b0;
        mid();
        chk("ab_late_return_ignored", rdata_valid_o, 0);
        chk("ab_no_done_later", done_o, 0);

        // Normal write after abort
        nxt();
        wdata_valid_i = 1'b1;
        wdata_i       = 32'hC0;
        nxt();
        wdata_i = 32'hC1;
        nxt();
        wdata_valid_i = 1'b0;
        cmd_valid_i   = 1'b1;
        cmd_wen_i     = 1'b1;
        cmd_addr_i    = 32'h300;
        cmd_len_i     = 16'd2;
        nxt();
        cmd_valid_i = 1'b0;
        mid();
        chk("pa_addr0", bus_addr_o, 64'h0300);
        chk("pa_data0", bus_data_o, 64'h00C0);
        nxt();
        mid();
        chk("pa_addr1", bus_addr_o, 64'h0301);
        chk("pa_data1", bus_data_o, 64'h00C1);
        nxt();
        mid();
        chk("pa_done", done_o, 1);
        chk("pa_error", error_o, 0);

        // Stall: read len 1 with bus_ready held low; request must hold steady
        nxt();
        bus_ready_i = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_wen_i   = 1'b0;
        cmd_addr_i  = 32'h400;
        cmd_len_i   = 16'd1;
        nxt();
        cmd_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("st_valid_hold", bus_valid_o, 1);
            chk("st_addr_hold", bus_addr_o, 64'h0400);
            nxt();
        end
`ifdef QRACC_BUS_INITIATOR_TIMEOUT_EN
        mid();
        chk("to_error_set", error_o, 1);
        chk("to_busy_clear", busy_o, 0);
        chk("to_bus_idle", bus_valid_o, 0);
        chk("to_no_done", done_o, 0);
        nxt();
        abort_i = 1'b1;
        nxt();
        abort_i = 1'b0;
        mid();
        chk("to_error_sticky", error_o, 1);
        nxt();
        nrst = 1'b0;
        #1;
        chk("to_error_reset", error_o, 0);
        nxt();
        nrst = 1'b1;
        mid();
        chk("to_after_reset_ready", cmd_ready_o, 1);
`else
        bus_ready_i = 1'b1;
        mid();
        chk("st_no_error", error_o, 0);
        chk("st_still_busy", busy_o, 1);
        chk("st_still_valid", bus_valid_o, 1);
        nxt();
        bus_ready_i         = 1'b0;
        bus_rd_data_valid_i = 1'b1;
        bus_rd_data_i       = 32'hF0;
        mid();
        chk("st_req_done", bus_valid_o, 0);
        nxt();
        bus_rd_data_valid_i = 1'b0;
        mid();
        chk("st_done", done_o, 1);
        chk("st_rdata", rdata_o, 64'h00F0);
        chk("st_error_tied", error_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qracc_bus_initiator.md
# qracc_bus_initiator

Bus-master counterpart to the QRAcc controller's data interface. It accepts burst commands (write N beats or read N beats from a start address) and drives the accelerator-side valid/ready data bus. Write payload is buffered in a small FIFO, and read returns are buffered in an output FIFO. It sits between the host/DMA fabric and the QRAcc data port, and streams weights, activations and scalers in and ofmaps out.

## Interface
- DATA_W, 128: bus data width (internal interface width)
- ADDR_W, 32: bus address width
- LEN_W, 16: burst length counter width
- FIFO_DEPTH, 4: depth of write and read FIFOs (power of two, ≥2)
- TIMEOUT_CYCLES, 1024: stall watchdog limit (only with macro)

Ports:
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_wen_i  in  1  1 = write burst, 0 = read burst
- cmd_addr_i  in  ADDR_W  start address
- cmd_len_i  in  LEN_W  beat count
- abort_i  in  1  synchronous abort
- wdata_valid_i / wdata_ready_o / wdata_i  in/out/in  1/1/DATA_W  write payload stream
- rdata_valid_o / rdata_ready_i / rdata_o  out/in/out  1/1/DATA_W  read return stream
- bus_valid_o  out  1  bus request
- bus_ready_i  in  1  responder accepts
- bus_wen_o  out  1  request is a write
- bus_addr_o  out  ADDR_W  request address
- bus_data_o  out  DATA_W  write data
- bus_rd_data_i  in  DATA_W  read data
- bus_rd_data_valid_i  in  1  read data valid
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle burst-complete pulse
- error_o  out  1  sticky timeout flag

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: cmd_ready_o=1. A handshake latches addr, len and wen, and clears beat counters. Next state: DONE if len==0, else WRITE or READ.
- WRITE:
  - bus_valid_o=1 and bus_wen_o=1 whenever the wdata FIFO is non-empty.
  - bus_data_o = FIFO head; bus_addr_o = base + issued_count (modulo 2^ADDR_W).
  - On bus_valid_o&&bus_ready_i: pop the FIFO and increment issued_count.
  - The handshake on the last beat (issued_count==len-1) moves to DONE.
- READ:
  - bus_valid_o=1 and bus_wen_o=0 while issued_count<len and credit>0.
  - credit = FIFO_DEPTH − rfifo_count − outstanding.
  - outstanding increments on a request handshake and decrements on bus_rd_data_valid_i.
  - Each bus_rd_data_valid_i pushes bus_rd_data_i and increments returned_count.
  - returned_count==len moves to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- The wdata FIFO accepts data in any state, which allows prefill. wdata_ready_o = !full, with no same-cycle bypass when full.
- The rdata FIFO is first-word-fall-through: rdata_valid_o = !empty.
- bus_rd_data_valid_i outside READ, or after returned_count==len, is ignored (no push).
- Once bus_valid_o is asserted, bus_addr_o, bus_data_o and bus_wen_o hold until the handshake.
- abort_i (any state):
  - Next state IDLE; both FIFOs flushed; counters cleared.
  - No done_o pulse; error_o unchanged.
  - abort_i has priority over every other event.
- Reset values: all outputs 0 except cmd_ready_o=1 and wdata_ready_o=1. FIFOs empty, state IDLE.

## Timing
- cmd handshake at cycle 0 → bus_valid_o earliest at cycle 1 (registered state).
- Throughput is one beat per cycle when bus_ready_i=1 and data/credit are available.
- bus_rd_data_valid_i at cycle t → rdata_valid_o at cycle t+1.
- done_o fires one cycle after the last write handshake or the last read return.
- A simultaneous FIFO push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- cmd_ready_o is 0 from the cycle after acceptance until IDLE. A new command can be accepted in the cycle after DONE.

## Configuration
- QRACC_BUS_INITIATOR_TIMEOUT_EN defined:
  - A counter runs while bus_valid_o=1 && bus_ready_i=0, and clears on handshake.
  - When it reaches TIMEOUT_CYCLES: error_o is set (sticky until reset), state goes to IDLE, FIFOs are flushed, and there is no done_o pulse.
- Undefined: no counter is instantiated and error_o is tied to 0.

## Test plan
- Write burst: prefill 4 beats, cmd wen=1 addr=0x10 len=4, bus_ready_i=1 → addresses 0x10..0x13 on cycles 1..4 with matching data, done_o at cycle 5.
- Read burst with backpressure: len=6, rdata_ready_i=0 → at most 4 requests issued (credit exhaustion). Releasing ready completes all 6 beats in order, then done_o.
- len=0 command → no bus_valid_o, done_o one cycle after acceptance.
- Address wrap: addr=0xFFFFFFFE, len=3 → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Abort mid-read after 2 returns → IDLE next cycle, rdata_valid_o=0, no done_o. A following write burst completes normally.
- Timeout (macro on, TIMEOUT_CYCLES=8): bus_ready_i held 0 → error_o=1 after 8 stalled cycles, busy_o=0. Only nrst clears error_o.
